// File: rtl/ysyx_24090010_mem_arb.sv
// Shared memory port arbiter between IFU fetches and LSU loads/stores.
// LSU has priority, bounded by a streak limit so IFU always makes progress.
module ysyx_24090010_mem_arb #(
    parameter int MAX_LSU_STREAK = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy,
    output logic                owner
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [SW-1:0] streak;
    logic          idle;
    logic          lsu_win;
    logic          ifu_win;
    logic          grant;
    logic          resp_fire;

    assign idle    = (state == IDLE);
    assign lsu_win = lsu_req_valid && !(ifu_req_valid && streak == STREAK_MAX);
    assign ifu_win = ifu_req_valid && !lsu_win;
    // Never hand out a grant while reset is held.
    assign grant   = idle && !rst && (lsu_win || ifu_win);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RESP;
            RESP:    if (mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant) begin
            owner     <= lsu_win;
            mem_addr  <= lsu_win ? lsu_addr : ifu_addr;
            mem_wen   <= lsu_win && lsu_wen;
            mem_wdata <= lsu_win ? lsu_wdata : '0;
            mem_wmask <= lsu_win ? lsu_wmask : '0;
        end
    end

    // Streak counts LSU wins only while IFU is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant) begin
            if (lsu_win && ifu_req_valid) begin
                if (streak != STREAK_MAX) streak <= streak + SW'(1);
            end else begin
                streak <= '0;
            end
        end
    end

    assign resp_fire      = (state == RESP) && mem_resp_valid;

    assign ifu_req_ready  = grant && ifu_win;
    assign lsu_req_ready  = grant && lsu_win;
    assign mem_req_valid  = (state == REQ);
    assign busy           = !idle;

    assign ifu_resp_valid = resp_fire && !owner;
    assign lsu_resp_valid = resp_fire && owner;
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_24090010_mem_arb.sv
// Bench for ysyx_24090010_mem_arb: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level model.
module tb_ysyx_24090010_mem_arb;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        owner;

    ysyx_24090010_mem_arb #(
        .MAX_LSU_STREAK(MAXS), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: is a transaction in flight, and has memory taken it yet.
    bit          m_inflight;
    bit          m_accepted;
    bit          m_owner;
    logic [31:0] m_addr;
    bit          m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    int          m_streak;

    int grants[$];
    int ifu_resp_cnt;
    int lsu_resp_cnt;
    bit last_ifu_gnt;
    bit last_lsu_gnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0; m_accepted = 0; m_owner = 0;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
        m_streak = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_valid = 0; lsu_req_valid = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle();
        bit lw, iw, waiting_resp, rv;
        #2;
        lw = 0; iw = 0;
        if (!m_inflight) begin
            lw = lsu_req_valid && !(ifu_req_valid && m_streak == MAXS);
            iw = ifu_req_valid && !lw;
        end
        waiting_resp = m_inflight && m_accepted;
        rv = waiting_resp && mem_resp_valid;
        chk("ifu_req_ready", ifu_req_ready, iw);
        chk("lsu_req_ready", lsu_req_ready, lw);
        chk("mem_req_valid", mem_req_valid, m_inflight && !m_accepted);
        chk("busy", busy, m_inflight);
        chk("owner", owner, m_owner);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
        chk("ifu_resp_valid", ifu_resp_valid, rv && !m_owner);
        chk("lsu_resp_valid", lsu_resp_valid, rv && m_owner);
        chk("ifu_rdata", ifu_rdata, (rv && !m_owner) ? mem_rdata : 32'h0);
        chk("lsu_rdata", lsu_rdata, (rv && m_owner) ? mem_rdata : 32'h0);
        last_ifu_gnt = ifu_req_ready;
        last_lsu_gnt = lsu_req_ready;
        if (ifu_req_ready) grants.push_back(0);
        if (lsu_req_ready) grants.push_back(1);
        ifu_resp_cnt += int'(ifu_resp_valid);
        lsu_resp_cnt += int'(lsu_resp_valid);
        if (lw || iw) begin
            m_inflight = 1; m_accepted = 0; m_owner = lw;
            m_addr  = lw ? lsu_addr : ifu_addr;
            m_wen   = lw && lsu_wen;
            m_wdata = lw ? lsu_wdata : 32'h0;
            m_wmask = lw ? lsu_wmask : 4'h0;
            if (lw && ifu_req_valid) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            else m_streak = 0;
        end else if (m_inflight && !m_accepted) begin
            if (mem_req_ready) m_accepted = 1;
        end else if (rv) begin
            m_inflight = 0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_c[6];
        model_reset();
        #1;
        do_reset();
        ifu_resp_cnt = 0; lsu_resp_cnt = 0;

        // Idle after reset: everything low.
        repeat (2) cycle();

        // IFU read alone.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        cycle();
        ifu_req_valid = 0;
        cycle();
        chk("ifu_rd_addr", mem_addr, 32'h8000_0000);
        chk("ifu_rd_wen", mem_wen, 0);
        mem_req_ready = 1;
        cycle();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        cycle();
        mem_resp_valid = 0;
        repeat (2) cycle();
        chk("ifu_resp_count", ifu_resp_cnt, 1);
        chk("lsu_resp_count_ifu", lsu_resp_cnt, 0);

        // LSU write.
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        cycle();
        lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        cycle();
        chk("lsu_wr_addr", mem_addr, 32'h8000_1000);
        chk("lsu_wr_data", mem_wdata, 32'hDEAD_BEEF);
        chk("lsu_wr_mask", mem_wmask, 4'hF);
        chk("lsu_wr_wen", mem_wen, 1);
        chk("lsu_wr_owner", owner, 1);
        mem_req_ready = 1;
        cycle();
        mem_req_ready = 0; mem_resp_valid = 1;
        cycle();
        mem_resp_valid = 0;
        cycle();
        chk("lsu_resp_count", lsu_resp_cnt, 1);

        // Contention: both hold valid continuously.
        do_reset();
        grants.delete();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
        mem_req_ready = 1; mem_resp_valid = 1;
        repeat (18) cycle();
        exp_c = '{1, 1, 1, 1, 0, 1};
        chk("contend_grants", grants.size(), 6);
        foreach (exp_c[i])
            if (i < grants.size()) chk("contend_order", grants[i], exp_c[i]);

        // Streak clear when IFU drops out for one LSU grant.
        do_reset();
        grants.delete();
        mem_req_ready = 1; mem_resp_valid = 1; lsu_req_valid = 1;
        for (int g = 0; g < 8; g++) begin
            ifu_req_valid = (g != 2);
            repeat (3) cycle();
        end
        chk("clear_grants", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            chk("clear_order", grants[i], (i == 7) ? 0 : 1);

        // Stray mem_resp_valid in IDLE.
        do_reset();
        ifu_req_valid = 0; lsu_req_valid = 0;
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        repeat (3) cycle();
        mem_resp_valid = 0;

        // REQ held for 10 cycles while requesters churn.
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 1;
        lsu_wdata = 32'hCAFE_0001; lsu_wmask = 4'h3;
        cycle();
        ifu_req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            lsu_addr = $urandom; lsu_wdata = $urandom;
            cycle();
        end
        chk("hold_addr", mem_addr, 32'h8000_3000);
        chk("hold_wdata", mem_wdata, 32'hCAFE_0001);

        // Async reset mid-REQ.
        ifu_req_valid = 0; lsu_req_valid = 0;
        #2; rst = 1; #1;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        ifu_resp_cnt = 0; lsu_resp_cnt = 0;
        mem_resp_valid = 1; mem_req_ready = 1;
        repeat (4) cycle();
        chk("rst_no_resp", ifu_resp_cnt + lsu_resp_cnt, 0);
        mem_resp_valid = 0; mem_req_ready = 0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (last_ifu_gnt) ifu_req_valid = 0;
            if (last_lsu_gnt) lsu_req_valid = 0;
            if (!ifu_req_valid && ($urandom % 3 != 0)) begin
                ifu_req_valid = 1; ifu_addr = $urandom;
            end
            if (!lsu_req_valid && ($urandom % 2 == 0)) begin
                lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = $urandom;
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            end
            mem_req_ready  = ($urandom % 3 != 0);
            mem_resp_valid = ($urandom % 2 == 0);
            mem_rdata      = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24090010_mem_arb.md
Name: ysyx_24090010_mem_arb

Overview:
- Arbitrates a single shared memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the NPC core.
- Sequences each transaction with a 3-state FSM, one transaction outstanding at a time.
- Latches the winning request, presents it downstream, and routes the response back to its owner.
- LSU has fixed priority, with a streak limit so IFU cannot starve.

Parameters:
- MAX_LSU_STREAK, 4: maximum consecutive LSU grants while IFU is pending; the next grant then goes to IFU. Must be ≥ 1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. The wmask width is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse).
- ifu_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  LSU response pulse (read data or write ack).
- lsu_rdata  out  DATA_W  LSU read data.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts the request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched request fields.
- mem_resp_valid  in  1  downstream response valid.
- mem_rdata  in  DATA_W  downstream read data.
- busy  out  1  FSM not in IDLE.
- owner  out  1  owner of the current transaction: 0 = IFU, 1 = LSU.

Behaviour:
- Reset (async, immediate):
  - State → IDLE.
  - All outputs 0, including the latched mem_* fields, owner and the streak counter.
  - Any in-flight transaction is dropped; no response is delivered to either requester.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Winner selection when any req_valid is high:
    - LSU wins if lsu_req_valid, unless ifu_req_valid && streak == MAX_LSU_STREAK, in which case IFU wins.
    - Otherwise IFU wins if ifu_req_valid.
  - The winner's req_ready is high combinationally in that cycle; the loser's req_ready stays 0.
  - On the clock edge: latch addr/wen/wdata/wmask (IFU forces wen = 0, wmask = 0, wdata = 0), set owner, go to REQ.
  - req_ready is never high outside IDLE.
- REQ:
  - mem_req_valid = 1 with the latched fields held stable.
  - mem_req_ready = 1 → go to RESP. Otherwise hold in REQ indefinitely.
- RESP:
  - mem_req_valid = 0.
  - On mem_resp_valid: the owner's resp_valid = 1 in the same cycle (combinational), with rdata = mem_rdata; go to IDLE.
  - The non-owner's resp_valid is always 0.
- Response data: ifu_rdata and lsu_rdata are mem_rdata gated by their resp_valid (0 otherwise).
- mem_resp_valid in IDLE or REQ is ignored.
- Minimum transaction time: 3 cycles (accept, request, response). The next accept can happen in the cycle after the response.
- Streak counter, width clog2(MAX_LSU_STREAK+1), updated on each grant:
  - LSU grant with ifu_req_valid high: increment, saturating at MAX_LSU_STREAK.
  - LSU grant with IFU idle: clear.
  - IFU grant: clear.
- Simultaneous requests at streak < MAX → LSU. At streak == MAX → IFU, then the counter clears.
- A requester must hold valid and its fields until ready. If valid drops before a grant, no transaction is issued.
- The latched fields do not change between accept and return to IDLE, regardless of requester inputs.

Test Plan:
- Reset then idle: rst high mid-REQ with mem_req_ready = 0 → mem_req_valid drops asynchronously. All outputs 0, busy = 0, no resp_valid afterwards.
- IFU read alone: ifu_addr = 0x80000000. Memory gives ready after 2 cycles and rdata = 0x00000413 one cycle later. Required:
  - ifu_req_ready pulses in cycle 0.
  - mem_addr = 0x80000000 with mem_wen = 0.
  - ifu_resp_valid = 1 with ifu_rdata = 0x00000413 exactly once.
  - lsu_resp_valid stays 0.
- LSU write: addr = 0x80001000, wdata = 0xDEADBEEF, wmask = 0xF, wen = 1 → mem fields match while in REQ. lsu_resp_valid pulses on mem_resp_valid. owner = 1 throughout.
- Contention priority: both valid continuously with MAX_LSU_STREAK = 4 → grant order LSU, LSU, LSU, LSU, IFU, LSU… The 5th grant is IFU.
- Streak clear: 2 LSU grants with IFU pending, IFU deasserts for one LSU grant, then IFU reasserts → 4 more LSU grants occur before IFU wins.
- Stray/late handshakes:
  - mem_resp_valid asserted in IDLE → no resp_valid output.
  - mem_req_ready held 0 for 10 cycles in REQ → FSM stays in REQ with fields stable and no req_ready to either requester.
